// File: rtl/sysbus_mem_responder_if.sv
// ----------------------------------------------------------------------------
// sysbus_mem_responder_if
//   Sysbus line-transfer bundle between a requester (MemArbiter side) and a
//   memory-side responder.
//
//   Signals
//     reqcyc   requester -> responder  request/write-data valid
//     req      requester -> responder  header address or write data beat
//     reqtag   requester -> responder  {rw, type[3:0], id[7:0]}
//     respack  requester -> responder  current response beat accepted
//     reqack   responder -> requester  one-cycle header acceptance pulse
//     respcyc  responder -> requester  read response beat valid
//     resp     responder -> requester  read response data
//     resptag  responder -> requester  echo of the accepted reqtag
//
//   Modports: master = requester, slave = responder.
// ----------------------------------------------------------------------------
interface sysbus_mem_responder_if #(
  parameter int TAG_W = 13
);
  logic             reqcyc;
  logic [63:0]      req;
  logic [TAG_W-1:0] reqtag;
  logic             reqack;
  logic             respcyc;
  logic [63:0]      resp;
  logic [TAG_W-1:0] resptag;
  logic             respack;

  modport master (
    output reqcyc, req, reqtag, respack,
    input  reqack, respcyc, resp, resptag
  );

  modport slave (
    input  reqcyc, req, reqtag, respack,
    output reqack, respcyc, resp, resptag
  );
endinterface

// File: rtl/sysbus_mem_responder.sv
// ----------------------------------------------------------------------------
// sysbus_mem_responder
//   Memory-side responder for the Sysbus line-transfer protocol. Accepts one
//   request at a time, acknowledges the header with a single-cycle pulse and
//   moves a 64-byte line as 8 x 64-bit beats. Reads stream the line back with
//   the request tag echoed; writes absorb 8 data beats into the store. The
//   internal line array stands in for DRAM in core-level simulation.
//
//   Parameters
//     LATENCY    cycles from reqack to the first read response beat (>= 1)
//     MEM_LINES  number of 64-byte lines held in the store (power of 2)
//     TAG_W      tag width, layout {rw, type[3:0], id[7:0]}
//
//   Ports
//     clk      in   single clock, all logic on the rising edge
//     reset_n  in   asynchronous active-low reset
//     bus      slave modport of sysbus_mem_responder_if
// ----------------------------------------------------------------------------
module sysbus_mem_responder #(
  parameter int LATENCY   = 8,
  parameter int MEM_LINES = 1024,
  parameter int TAG_W     = 13
) (
  input logic                   clk,
  input logic                   reset_n,
  sysbus_mem_responder_if.slave bus
);

  localparam int         LINE_W      = $clog2(MEM_LINES);
  localparam int         WAIT_W      = $clog2(LATENCY + 1);
  localparam logic [3:0] TYPE_MEMORY = 4'b0001;

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    RWAIT,
    RDATA,
    WDATA
  } state_e;

  state_e             state_q;
  logic [LINE_W-1:0]  line_q;
  logic [TAG_W-1:0]   tag_q;
  logic [2:0]         beat_q;
  logic [WAIT_W-1:0]  wait_q;
  logic               reqack_q;
  logic               respcyc_q;
  logic [63:0]        resp_q;
  logic [TAG_W-1:0]   resptag_q;

  // Store is addressed as {line, beat}: eight consecutive words per line.
  logic [63:0]        store [MEM_LINES*8];

  logic               isMem;
  logic               wrEn_d;
  logic [2:0]         rdBeat_d;
  logic [63:0]        rdWord_d;

  assign isMem  = (tag_q[11:8] == TYPE_MEMORY);
  assign wrEn_d = (state_q == WDATA) && bus.reqcyc && isMem;

  // The word that will be presented on resp at the next beat boundary:
  // beat 0 when a read is about to start, otherwise the beat after the one
  // currently on the bus. Non-MEMORY requests read as zero.
  always_comb begin
    rdBeat_d = 3'd0;
    if (state_q == RDATA) begin
      rdBeat_d = beat_q + 3'd1;
    end
    rdWord_d = isMem ? store[{line_q, rdBeat_d}] : 64'h0;
  end

  // Backing store write port. Contents deliberately survive reset so that a
  // core-level test can reset the system without losing memory.
  always_ff @(posedge clk) begin
    if (wrEn_d) begin
      store[{line_q, beat_q}] <= bus.req;
    end
  end

  // Transfer sequencer. All bus outputs are registered here, so each state
  // loads the values the next cycle must show. The wait counter therefore
  // leaves RWAIT on the 1->0 step, which makes respcyc appear exactly
  // LATENCY cycles after the reqack cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      line_q    <= '0;
      tag_q     <= '0;
      beat_q    <= '0;
      wait_q    <= '0;
      reqack_q  <= 1'b0;
      respcyc_q <= 1'b0;
      resp_q    <= '0;
      resptag_q <= '0;
    end else begin
      reqack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.reqcyc) begin
            // Offset bits [5:0] are dropped; upper bits wrap by truncation.
            line_q   <= bus.req[6 +: LINE_W];
            tag_q    <= bus.reqtag;
            reqack_q <= 1'b1;
            state_q  <= ACK;
          end
        end

        ACK: begin
          beat_q <= 3'd0;
          if (tag_q[12]) begin
            if (LATENCY == 1) begin
              respcyc_q <= 1'b1;
              resp_q    <= rdWord_d;
              resptag_q <= tag_q;
              state_q   <= RDATA;
            end else begin
              wait_q  <= WAIT_W'(LATENCY - 1);
              state_q <= RWAIT;
            end
          end else begin
            state_q <= WDATA;
          end
        end

        RWAIT: begin
          wait_q <= wait_q - 1'b1;
          if (wait_q == WAIT_W'(1)) begin
            respcyc_q <= 1'b1;
            resp_q    <= rdWord_d;
            resptag_q <= tag_q;
            state_q   <= RDATA;
          end
        end

        RDATA: begin
          // Beat is held until the requester accepts it.
          if (bus.respack) begin
            beat_q <= beat_q + 3'd1;
            if (beat_q == 3'd7) begin
              respcyc_q <= 1'b0;
              state_q   <= IDLE;
            end else begin
              resp_q <= rdWord_d;
            end
          end
        end

        WDATA: begin
          // reqcyc low is a bubble: nothing written, beat not advanced.
          if (bus.reqcyc) begin
            beat_q <= beat_q + 3'd1;
            if (beat_q == 3'd7) begin
              state_q <= IDLE;
            end
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.reqack  = reqack_q;
  assign bus.respcyc = respcyc_q;
  assign bus.resp    = resp_q;
  assign bus.resptag = resptag_q;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_sysbus_mem_responder
//   Directed testbench for sysbus_mem_responder. A transaction-level model
//   (line store as an associative array, expected read beats in a queue)
//   predicts reqack, respcyc, resp and resptag every cycle; directed
//   sequences add hand-computed literal checks.
// ----------------------------------------------------------------------------
module tb_sysbus_mem_responder;

  localparam int         LATENCY   = 8;
  localparam int         MEM_LINES = 1024;
  localparam int         TAG_W     = 13;
  localparam logic [3:0] T_MEM     = 4'b0001;
  localparam logic [3:0] T_MMIO    = 4'b0011;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;
  int   checks  = 0;
  int   errors  = 0;

  sysbus_mem_responder_if #(.TAG_W(TAG_W)) bus ();

  sysbus_mem_responder #(
    .LATENCY  (LATENCY),
    .MEM_LINES(MEM_LINES),
    .TAG_W    (TAG_W)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  // Comparison helper shared by the model checker and the directed checks.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level model: one transfer at a time, store as word array.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [63:0]      data;
    logic [TAG_W-1:0] tag;
  } beat_t;

  logic [63:0] mdl [int];
  beat_t       expQ [$];
  bit          busy       = 1'b0;
  bit          mdlRead    = 1'b0;
  bit          mdlIsMem   = 1'b0;
  int          mdlLine    = 0;
  int          wBeats     = 0;
  int          expAckCyc  = -1;
  int          firstResp  = 0;
  bit          expValid;
  beat_t       nb;

  function automatic logic [63:0] mdlWord(input int key);
    if (mdl.exists(key)) return mdl[key];
    return 64'h0;
  endfunction

  // Checker: outputs at the negedge reflect the last rising edge; inputs at
  // the negedge are what the next rising edge will sample.
  always @(negedge clk) begin
    if (!reset_n) begin
      busy      = 1'b0;
      expQ.delete();
      expAckCyc = -1;
      wBeats    = 0;
      checkOutput("rst_reqack",  64'(bus.reqack),  64'h0);
      checkOutput("rst_respcyc", 64'(bus.respcyc), 64'h0);
      checkOutput("rst_resp",    bus.resp,         64'h0);
      checkOutput("rst_resptag", 64'(bus.resptag), 64'h0);
    end else begin
      checkOutput("reqack", 64'(bus.reqack), 64'(cyc == expAckCyc));
      expValid = busy && mdlRead && (cyc >= firstResp) && (expQ.size() > 0);
      checkOutput("respcyc", 64'(bus.respcyc), 64'(expValid));
      if (expValid && bus.respcyc) begin
        checkOutput("resp",    bus.resp,         expQ[0].data);
        checkOutput("resptag", 64'(bus.resptag), 64'(expQ[0].tag));
      end

      if (!busy && bus.reqcyc) begin
        busy      = 1'b1;
        mdlRead   = bus.reqtag[12];
        mdlIsMem  = (bus.reqtag[11:8] == T_MEM);
        mdlLine   = int'((bus.req >> 6) % MEM_LINES);
        expAckCyc = cyc + 1;
        firstResp = expAckCyc + LATENCY;
        wBeats    = 0;
        if (mdlRead) begin
          for (int b = 0; b < 8; b++) begin
            nb.data = mdlIsMem ? mdlWord(mdlLine * 8 + b) : 64'h0;
            nb.tag  = bus.reqtag;
            expQ.push_back(nb);
          end
        end
      end else if (busy && !mdlRead && cyc > expAckCyc && bus.reqcyc) begin
        if (mdlIsMem) mdl[mdlLine * 8 + wBeats] = bus.req;
        wBeats++;
        if (wBeats == 8) busy = 1'b0;
      end else if (expValid && bus.respack) begin
        void'(expQ.pop_front());
        if (expQ.size() == 0) busy = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [63:0] rxBuf [8];
  int          rxLat;

  // Drive a header and wait (bounded) for reqack. In the ack cycle reqcyc is
  // left high with junk data, which the responder must ignore.
  task automatic applyStimulus(input logic [63:0] addr, input logic [TAG_W-1:0] tag,
                               output int ackCyc);
    @(posedge clk); #1;
    bus.reqcyc = 1'b1;
    bus.req    = addr;
    bus.reqtag = tag;
    ackCyc     = -1;
    for (int g = 0; g < 4; g++) begin
      @(posedge clk); #1;
      if (bus.reqack) begin
        ackCyc = cyc;
        break;
      end
    end
    if (ackCyc < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL header_ack_timeout: got no reqack, expected one within 4 cycles");
      bus.reqcyc = 1'b0;
    end else begin
      bus.req = 64'hDEAD_BEEF_0BAD_F00D;
    end
  endtask

  task automatic writeLine(input logic [63:0] addr, input logic [TAG_W-1:0] tag,
                           input logic [63:0] base, input int bubbleBefore, input int bubbles);
    int ackCyc;
    applyStimulus(addr, tag, ackCyc);
    for (int b = 0; b < 8; b++) begin
      if (b == bubbleBefore) begin
        repeat (bubbles) begin
          @(posedge clk); #1;
          bus.reqcyc = 1'b0;
          bus.req    = 64'hBAD0_BAD0_BAD0_BAD0;
        end
      end
      @(posedge clk); #1;
      bus.reqcyc = 1'b1;
      bus.req    = base + 64'(b);
    end
    @(posedge clk); #1;
    bus.reqcyc = 1'b0;
  endtask

  // Read a line into rxBuf, optionally holding respack low for stallCycles
  // cycles while beat stallBeat is on the bus. rxLat = cycles from reqack to
  // the first respcyc.
  task automatic readLine(input logic [63:0] addr, input logic [TAG_W-1:0] tag,
                          input int stallBeat, input int stallCycles);
    int          ackCyc, beats, guard, stallLeft;
    bit          prevValid, prevAck, seenFirst;
    logic [63:0] prevData;
    applyStimulus(addr, tag, ackCyc);
    beats = 0; guard = 0; prevValid = 0; prevAck = 0; seenFirst = 0;
    prevData = '0; stallLeft = stallCycles; rxLat = -1;
    for (int i = 0; i < 8; i++) rxBuf[i] = 64'hFFFF_FFFF_FFFF_FFFF;
    while (beats < 8 && guard < LATENCY + 64) begin
      @(posedge clk); #1;
      guard++;
      bus.reqcyc = 1'b0;
      if (prevValid && prevAck) begin
        rxBuf[beats] = prevData;
        beats++;
      end
      if (beats == 8) break;
      if (bus.respcyc && !seenFirst) begin
        seenFirst = 1'b1;
        rxLat     = cyc - ackCyc;
      end
      prevValid = bus.respcyc;
      prevData  = bus.resp;
      if (bus.respcyc && beats == stallBeat && stallLeft > 0) begin
        bus.respack = 1'b0;
        stallLeft--;
      end else begin
        bus.respack = 1'b1;
      end
      prevAck = bus.respack;
    end
    bus.respack = 1'b0;
    if (beats < 8) begin
      checks++;
      errors++;
      $display("[TB] FAIL read_timeout: got %0d beats, expected 8", beats);
    end
  endtask

  // Main directed sequence.
  initial begin
    int beats, guard;
    int dummyAck;
    bit prevValid;

    bus.reqcyc  = 1'b0;
    bus.req     = '0;
    bus.reqtag  = '0;
    bus.respack = 1'b0;
    reset_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_reqack",  64'(bus.reqack),  64'h0);
    checkOutput("reset_respcyc", 64'(bus.respcyc), 64'h0);
    reset_n = 1'b1;

    // Write line 0x1000 with an incrementing pattern, read it back.
    writeLine(64'h1000, {1'b0, T_MEM, 8'h11}, 64'h1111_1111_1111_1111, -1, 0);
    readLine(64'h1000, {1'b1, T_MEM, 8'h5A}, -1, 0);
    checkOutput("t2_beat0",   rxBuf[0], 64'h1111_1111_1111_1111);
    checkOutput("t2_beat7",   rxBuf[7], 64'h1111_1111_1111_1118);
    checkOutput("t2_latency", 64'(rxLat), 64'd8);
    checkOutput("t2_model",   mdlWord(64 * 8 + 3), 64'h1111_1111_1111_1114);

    // Reset while beat 3 of a read is on the bus.
    applyStimulus(64'h1000, {1'b1, T_MEM, 8'h33}, dummyAck);
    beats = 0; guard = 0; prevValid = 0;
    bus.respack = 1'b1;
    while (guard < LATENCY + 32) begin
      @(posedge clk); #1;
      guard++;
      bus.reqcyc = 1'b0;
      if (prevValid) beats++;
      if (beats == 3 && bus.respcyc) break;
      prevValid = bus.respcyc;
    end
    if (guard >= LATENCY + 32) begin
      checks++;
      errors++;
      $display("[TB] FAIL t1_reach_beat3: got %0d beats, expected 3", beats);
    end
    checkOutput("t1_beat3", bus.resp, 64'h1111_1111_1111_1114);
    reset_n = 1'b0;
    #1;
    checkOutput("t1_rst_respcyc", 64'(bus.respcyc), 64'h0);
    checkOutput("t1_rst_reqack",  64'(bus.reqack),  64'h0);
    bus.respack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    readLine(64'h1000, {1'b1, T_MEM, 8'h34}, -1, 0);
    checkOutput("t1_after_beat3", rxBuf[3], 64'h1111_1111_1111_1114);

    // Read with respack held low for 3 cycles on beat 2.
    writeLine(64'h3000, {1'b0, T_MEM, 8'h30}, 64'hA0A0_0000_0000_0000, -1, 0);
    readLine(64'h3000, {1'b1, T_MEM, 8'h31}, 2, 3);
    checkOutput("t3_beat2", rxBuf[2], 64'hA0A0_0000_0000_0002);
    checkOutput("t3_beat3", rxBuf[3], 64'hA0A0_0000_0000_0003);

    // Write with bubbles between beats 4 and 5.
    writeLine(64'h2000, {1'b0, T_MEM, 8'h20}, 64'h2222_0000_0000_0000, 5, 2);
    readLine(64'h2000, {1'b1, T_MEM, 8'h21}, -1, 0);
    checkOutput("t4_beat4", rxBuf[4], 64'h2222_0000_0000_0004);
    checkOutput("t4_beat5", rxBuf[5], 64'h2222_0000_0000_0005);
    checkOutput("t4_beat7", rxBuf[7], 64'h2222_0000_0000_0007);

    // Offset bits ignored and address wrap.
    readLine(64'h1038, {1'b1, T_MEM, 8'h01}, -1, 0);
    checkOutput("t5_offset", rxBuf[0], 64'h1111_1111_1111_1111);
    readLine(64'(MEM_LINES * 64 + 'h1000), {1'b1, T_MEM, 8'h02}, -1, 0);
    checkOutput("t5_wrap", rxBuf[6], 64'h1111_1111_1111_1117);

    // Non-MEMORY type: zeros on read, write discarded.
    readLine(64'h1000, {1'b1, T_MMIO, 8'h66}, -1, 0);
    checkOutput("t6_mmio_beat0", rxBuf[0], 64'h0);
    checkOutput("t6_mmio_beat5", rxBuf[5], 64'h0);
    writeLine(64'h1000, {1'b0, T_MMIO, 8'h67}, 64'hFFFF_0000_0000_0000, -1, 0);
    readLine(64'h1000, {1'b1, T_MEM, 8'h68}, -1, 0);
    checkOutput("t6_store_kept", rxBuf[0], 64'h1111_1111_1111_1111);

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, expected completion before 200000");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
